// File: rtl/seg7_readback_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_readback_decoder_if
//  Description : Segment-bus sampling and digit-update handshake bundle for
//                seg7_readback_decoder.
//  Revision    : 1.0
// ============================================================================
interface seg7_readback_decoder_if #(
   parameter int NUM_DIGITS = 4
);
   logic [6:0]              seg_in;
   logic [NUM_DIGITS-1:0]   digit_sel;
   logic [4*NUM_DIGITS-1:0] digit_val;
   logic [NUM_DIGITS-1:0]   digit_ok;
   logic                    upd_valid;
   logic                    upd_ready;
   logic [2:0]              upd_idx;
   logic [3:0]              upd_digit;
   logic                    err_invalid;

   // Environment side: drives the display bus and consumes updates
   modport master (
      output seg_in, digit_sel, upd_ready,
      input  digit_val, digit_ok, upd_valid, upd_idx, upd_digit, err_invalid
   );

   // Decoder side
   modport slave (
      input  seg_in, digit_sel, upd_ready,
      output digit_val, digit_ok, upd_valid, upd_idx, upd_digit, err_invalid
   );
endinterface
`default_nettype wire

// File: rtl/seg7_readback_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_readback_decoder
//  Description : Recovers per-digit values from a multiplexed active-low
//                7-segment bus; optional macro HEX_LETTERS_EN adds A..F.
//  Revision    : 1.0
// ============================================================================
module seg7_readback_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  wire logic               clk,
   input  wire logic               reset,
   seg7_readback_decoder_if.slave  bus
);

   localparam logic [7:0] c_stable = 8'(STABLE_CYCLES);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } state_t;

   // Returns {valid, value}; blank and undecodable patterns return valid=0
   function automatic logic [4:0] f_decode(input logic [6:0] seg);
      logic [4:0] res;
      res = 5'h00;
      case (seg)
         7'h40: res = 5'h10;
         7'h79: res = 5'h11;
         7'h24: res = 5'h12;
         7'h30: res = 5'h13;
         7'h19: res = 5'h14;
         7'h12: res = 5'h15;
         7'h02: res = 5'h16;
         7'h78: res = 5'h17;
         7'h00: res = 5'h18;
         7'h18: res = 5'h19;
`ifdef HEX_LETTERS_EN
         7'h08: res = 5'h1A;
         7'h03: res = 5'h1B;
         7'h46: res = 5'h1C;
         7'h21: res = 5'h1D;
         7'h06: res = 5'h1E;
         7'h0E: res = 5'h1F;
`else
`endif
         default: res = 5'h00;
      endcase
      return res;
   endfunction

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [NUM_DIGITS-1:0]   r_samp_sel;
   logic [6:0]              r_samp_seg;
   logic [7:0]              r_cnt;
   logic                    r_done;
   logic [4*NUM_DIGITS-1:0] r_val;
   logic [NUM_DIGITS-1:0]   r_ok;
   logic [2:0]              r_upd_idx;
   logic [3:0]              r_upd_digit;
   logic                    r_err;

   logic                    w_in_onehot;
   logic                    w_same;
   logic                    w_fire;
   logic                    w_blank;
   logic [4:0]              w_dec;
   logic [3:0]              w_cur_val;
   logic                    w_cur_ok;
   logic [2:0]              w_idx;
   logic                    w_sample_en;
   logic                    w_cnt_clr;
   logic                    w_done_nxt;
   logic [4*NUM_DIGITS-1:0] w_val_nxt;
   logic [NUM_DIGITS-1:0]   w_ok_nxt;
   logic [2:0]              w_idx_nxt;
   logic [3:0]              w_digit_nxt;
   logic                    w_err_nxt;

   assign w_in_onehot = (bus.digit_sel != '0) &&
                        ((bus.digit_sel & (bus.digit_sel - 1'b1)) == '0);
   assign w_same      = (bus.digit_sel == r_samp_sel) && (bus.seg_in == r_samp_seg);
   assign w_dec       = f_decode(r_samp_seg);
   assign w_blank     = (r_samp_seg == 7'h7F);
   // A nonzero count implies the held sample carries a one-hot select
   assign w_fire      = (r_state == S_IDLE) && (r_cnt == c_stable) && !r_done;

   always_comb begin
      w_cur_val = 4'h0;
      w_cur_ok  = 1'b0;
      w_idx     = 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_samp_sel[i]) begin
            w_cur_val = r_val[4*i +: 4];
            w_cur_ok  = r_ok[i];
            w_idx     = 3'(i);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sample_en = 1'b0;
      w_cnt_clr   = 1'b0;
      w_done_nxt  = r_done;
      w_val_nxt   = r_val;
      w_ok_nxt    = r_ok;
      w_idx_nxt   = r_upd_idx;
      w_digit_nxt = r_upd_digit;
      w_err_nxt   = r_err;
      case (r_state)
         S_IDLE: begin
            w_sample_en = 1'b1;
            if (w_fire) begin
               w_done_nxt = 1'b1;
               if (w_dec[4]) begin
                  if (!w_cur_ok || (w_dec[3:0] != w_cur_val)) begin
                     for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (r_samp_sel[i]) begin
                           w_val_nxt[4*i +: 4] = w_dec[3:0];
                           w_ok_nxt[i]         = 1'b1;
                        end
                     end
                     w_idx_nxt   = w_idx;
                     w_digit_nxt = w_dec[3:0];
                     w_state_nxt = S_EMIT;
                  end
               end else begin
                  for (int i = 0; i < NUM_DIGITS; i++) begin
                     if (r_samp_sel[i]) begin
                        w_ok_nxt[i] = 1'b0;
                     end
                  end
                  if (!w_blank) begin
                     w_err_nxt = 1'b1;
                  end
               end
            end
         end
         S_EMIT: begin
            if (bus.upd_ready) begin
               w_state_nxt = S_IDLE;
               w_cnt_clr   = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_samp_sel  <= '0;
         r_samp_seg  <= 7'h00;
         r_cnt       <= 8'd0;
         r_done      <= 1'b0;
         r_val       <= '0;
         r_ok        <= '0;
         r_upd_idx   <= 3'd0;
         r_upd_digit <= 4'h0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_val       <= w_val_nxt;
         r_ok        <= w_ok_nxt;
         r_upd_idx   <= w_idx_nxt;
         r_upd_digit <= w_digit_nxt;
         r_err       <= w_err_nxt;
         r_done      <= w_done_nxt;
         if (w_cnt_clr) begin
            r_cnt <= 8'd0;
         end else if (w_sample_en) begin
            r_samp_sel <= bus.digit_sel;
            r_samp_seg <= bus.seg_in;
            // Only a change or a bad select starts a new stable episode
            if (!w_in_onehot) begin
               r_cnt  <= 8'd0;
               r_done <= 1'b0;
            end else if (!w_same) begin
               r_cnt  <= 8'd1;
               r_done <= 1'b0;
            end else if (r_cnt < c_stable) begin
               r_cnt <= r_cnt + 8'd1;
            end
         end
      end
   end

   assign bus.upd_valid   = (r_state == S_EMIT);
   assign bus.upd_idx     = r_upd_idx;
   assign bus.upd_digit   = r_upd_digit;
   assign bus.digit_val   = r_val;
   assign bus.digit_ok    = r_ok;
   assign bus.err_invalid = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_readback_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_readback_decoder
//  Description : Self-checking bench for seg7_readback_decoder against a
//                cycle-level reference model plus fixed expectations.
//  Revision    : 1.0
// ============================================================================
module tb_seg7_readback_decoder;
   localparam int N = 4;
   localparam int S = 3;

   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   seg7_readback_decoder_if #(.NUM_DIGITS(N)) bus ();

   seg7_readback_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   int         dec[int];
   int         m_val[N];
   logic [N-1:0] m_ok;
   logic       m_err, m_emit, m_done;
   int         m_idx, m_dig, m_run;
   logic [N-1:0] m_last_sel;
   logic [6:0] m_last_seg;

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_val[i] = 0;
      m_ok = '0; m_err = 0; m_emit = 0; m_done = 0;
      m_idx = 0; m_dig = 0; m_run = 0;
      m_last_sel = '0; m_last_seg = 7'h00;
   endtask

   task automatic model_step();
      int k;
      if (reset) begin
         model_reset();
         return;
      end
      if (m_emit) begin
         if (bus.upd_ready) begin
            m_emit = 0;
            m_run  = 0;
         end
         return;
      end
      if (m_run == S && !m_done) begin
         m_done = 1;
         k = 0;
         for (int i = 0; i < N; i++) if (m_last_sel[i]) k = i;
         if (dec.exists(int'(m_last_seg))) begin
            if (!m_ok[k] || m_val[k] != dec[int'(m_last_seg)]) begin
               m_val[k] = dec[int'(m_last_seg)];
               m_ok[k]  = 1'b1;
               m_emit   = 1;
               m_idx    = k;
               m_dig    = m_val[k];
            end
         end else if (m_last_seg == 7'h7F) begin
            m_ok[k] = 1'b0;
         end else begin
            m_ok[k] = 1'b0;
            m_err   = 1'b1;
         end
      end
      if ($countones(bus.digit_sel) != 1) begin
         m_run = 0; m_done = 0;
      end else if (bus.digit_sel == m_last_sel && bus.seg_in == m_last_seg) begin
         if (m_run < S) m_run++;
      end else begin
         m_run = 1; m_done = 0;
      end
      m_last_sel = bus.digit_sel;
      m_last_seg = bus.seg_in;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      dec[8'h40] = 0; dec[8'h79] = 1; dec[8'h24] = 2; dec[8'h30] = 3; dec[8'h19] = 4;
      dec[8'h12] = 5; dec[8'h02] = 6; dec[8'h78] = 7; dec[8'h00] = 8; dec[8'h18] = 9;
`ifdef HEX_LETTERS_EN
      dec[8'h08] = 10; dec[8'h03] = 11; dec[8'h46] = 12;
      dec[8'h21] = 13; dec[8'h06] = 14; dec[8'h0E] = 15;
`endif
      model_reset();
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Cycle-by-cycle comparison against the model
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("upd_valid", 32'(bus.upd_valid), 32'(m_emit));
         chk("upd_idx", 32'(bus.upd_idx), 32'(m_idx));
         chk("upd_digit", 32'(bus.upd_digit), 32'(m_dig));
         for (int i = 0; i < N; i++)
            chk("digit_val", 32'(bus.digit_val[4*i +: 4]), 32'(m_val[i]));
         chk("digit_ok", 32'(bus.digit_ok), 32'(m_ok));
         chk("err_invalid", 32'(bus.err_invalid), 32'(m_err));
      end
   end

   task automatic drive(input logic [6:0] seg, input logic [N-1:0] sel);
      bus.seg_in    = seg;
      bus.digit_sel = sel;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [6:0] pool[17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h18, 7'h7F, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   initial begin
      int         vcount;
      logic [3:0] d1;
      logic [N-1:0] sel;
      reset = 1'b1;
      drive(7'h7F, '0);
      bus.upd_ready = 1'b1;
      cyc(3);
      chk("rst_valid", 32'(bus.upd_valid), 32'd0);
      chk("rst_val", 32'(bus.digit_val), 32'd0);
      chk("rst_ok", 32'(bus.digit_ok), 32'd0);
      chk("rst_err", 32'(bus.err_invalid), 32'd0);

      // Digit 0 shows 2: update appears after STABLE_CYCLES+1 cycles as a pulse
      reset = 1'b0;
      drive(7'h24, 4'b0001);
      cyc(3);
      chk("t1_early", 32'(bus.upd_valid), 32'd0);
      cyc(1);
      chk("t1_valid", 32'(bus.upd_valid), 32'd1);
      chk("t1_idx", 32'(bus.upd_idx), 32'd0);
      chk("t1_digit", 32'(bus.upd_digit), 32'd2);
      chk("t1_val", 32'(bus.digit_val[3:0]), 32'd2);
      chk("t1_ok", 32'(bus.digit_ok), 32'b0001);
      cyc(1);
      chk("t1_pulse", 32'(bus.upd_valid), 32'd0);

      // Back-pressure holds the update steady
      bus.upd_ready = 1'b0;
      drive(7'h30, 4'b0001);
      cyc(4);
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_v", 32'(bus.upd_valid), 32'd1);
         chk("t2_hold_d", {bus.upd_idx, bus.upd_digit}, {3'd0, 4'd3});
         if (i < 4) cyc(1);
      end
      bus.upd_ready = 1'b1;
      cyc(1);
      chk("t2_release", 32'(bus.upd_valid), 32'd0);

      // Digit 2 shows 4, then blanks
      drive(7'h19, 4'b0100);
      cyc(4);
      chk("t3_upd", {bus.upd_valid, bus.upd_idx, bus.upd_digit}, {1'b1, 3'd2, 4'd4});
      cyc(1);
      drive(7'h7F, 4'b0100);
      cyc(6);
      chk("t3_blank_ok", 32'(bus.digit_ok[2]), 32'd0);
      chk("t3_blank_err", 32'(bus.err_invalid), 32'd0);

      // Letter pattern A on digit 1
      drive(7'h08, 4'b0010);
      cyc(4);
`ifdef HEX_LETTERS_EN
      chk("t4_letter", {bus.upd_valid, bus.upd_digit}, {1'b1, 4'hA});
      d1 = 4'hA;
`else
      chk("t4_err", 32'(bus.err_invalid), 32'd1);
      chk("t4_noupd", 32'(bus.upd_valid), 32'd0);
      d1 = 4'h0;
`endif
      cyc(2);

      // Non-one-hot selects change nothing
      drive(7'h40, 4'b0011);
      cyc(10);
      drive(7'h40, 4'b0000);
      cyc(10);
      chk("t5_val", 32'(bus.digit_val), 32'({4'h0, 4'h4, d1, 4'h3}));
`ifdef HEX_LETTERS_EN
      chk("t5_ok", 32'(bus.digit_ok), 32'b0011);
`else
      chk("t5_ok", 32'(bus.digit_ok), 32'b0001);
`endif

      // Pattern flicker never settles; then reset in the middle of an update
      vcount = 0;
      for (int i = 0; i < 12; i++) begin
         drive(((i / 2) % 2 == 0) ? 7'h00 : 7'h7F, 4'b1000);
         cyc(1);
         if (bus.upd_valid) vcount++;
      end
      chk("t6_flicker", 32'(vcount), 32'd0);
      bus.upd_ready = 1'b0;
      drive(7'h00, 4'b1000);
      cyc(4);
      chk("t6_emit", 32'(bus.upd_valid), 32'd1);
      reset = 1'b1;
      cyc(1);
      chk("t6_rst_v", 32'(bus.upd_valid), 32'd0);
      chk("t6_rst_ok", 32'(bus.digit_ok), 32'd0);
      reset = 1'b0;
      bus.upd_ready = 1'b1;

      // Randomized phase, checked by the model
      for (int seg_i = 0; seg_i < 300; seg_i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) sel = '0;
         else if (r == 1) sel = N'($urandom);
         else sel = N'(1) << $urandom_range(0, N-1);
         if ($urandom_range(0, 1) == 0) bus.seg_in = pool[$urandom_range(0, 16)];
         else bus.seg_in = 7'($urandom);
         bus.digit_sel = sel;
         reset = ($urandom_range(0, 39) == 0);
         for (int c = 0; c < int'($urandom_range(1, 7)); c++) begin
            bus.upd_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
            reset = 1'b0;
         end
      end

      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
